// File: rtl/mvm_output_framer.sv
// mvm_output_framer: requantizes the input_mems result stream and frames it
// as an AXI-stream of M-word vectors with TLAST, behind a small FIFO.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   IN_TDATA/TVALID/TREADY     signed INW-bit result stream from input_mems
//   cfg_shift, cfg_relu        rounding right-shift amount, negative clamp
//   OUT_TDATA/TVALID/TREADY    signed OUTW-bit framed output stream
//   OUT_TLAST                  marks word M-1 of each frame
//   frame_count                frames delivered downstream (wraps)
//   sat_flag                   sticky, some word was saturated
module mvm_output_framer #(
  parameter int INW   = 16,
  parameter int OUTW  = 8,
  parameter int M     = 4,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [INW-1:0]  IN_TDATA,
  input  logic            IN_TVALID,
  output logic            IN_TREADY,
  input  logic [3:0]      cfg_shift,
  input  logic            cfg_relu,
  output logic [OUTW-1:0] OUT_TDATA,
  output logic            OUT_TVALID,
  input  logic            OUT_TREADY,
  output logic            OUT_TLAST,
  output logic [15:0]     frame_count,
  output logic            sat_flag
);

  localparam int LOGD = $clog2(DEPTH);
  localparam int CW   = (M > 1) ? $clog2(M) : 1;

  localparam logic signed [INW:0] SMAX =
    {{(INW-OUTW+2){1'b0}}, {(OUTW-1){1'b1}}};
  localparam logic signed [INW:0] SMIN = ~SMAX;

  localparam logic [LOGD:0] FULL = (LOGD+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(M-1);

  logic signed [INW:0] x_ext;
  logic signed [INW:0] bias;
  logic signed [INW:0] y_rnd;
  logic signed [INW:0] y_rel;
  logic [OUTW-1:0]     y_sat;
  logic                sat_hit;

  logic [OUTW:0]   mem [DEPTH];
  logic [LOGD-1:0] wr_ptr;
  logic [LOGD-1:0] rd_ptr;
  logic [LOGD:0]   count;
  logic [CW-1:0]   word_idx;
  logic            push;
  logic            pop;
  logic            last_in;
  logic [OUTW:0]   head;

  // Headroom bit in x_ext keeps x + bias from overflowing.
  always_comb begin
    x_ext   = {IN_TDATA[INW-1], IN_TDATA};
    bias    = '0;
    y_rnd   = x_ext;
    y_rel   = '0;
    y_sat   = '0;
    sat_hit = 1'b0;
    if (cfg_shift != 4'd0) begin
      bias  = {{INW{1'b0}}, 1'b1} << (cfg_shift - 4'd1);
      y_rnd = (x_ext + bias) >>> cfg_shift;
    end
    y_rel = y_rnd;
    if (cfg_relu && y_rnd[INW]) begin
      y_rel = '0;
    end
    if (y_rel > SMAX) begin
      y_sat   = SMAX[OUTW-1:0];
      sat_hit = 1'b1;
    end else if (y_rel < SMIN) begin
      y_sat   = SMIN[OUTW-1:0];
      sat_hit = 1'b1;
    end else begin
      y_sat = y_rel[OUTW-1:0];
    end
  end

  // Ready depends only on registered occupancy, never on OUT_TREADY.
  assign IN_TREADY  = (count != FULL);
  assign OUT_TVALID = (count != '0);
  assign push       = IN_TVALID && IN_TREADY;
  assign pop        = OUT_TVALID && OUT_TREADY;
  assign last_in    = (word_idx == LAST_IDX);
  assign head       = mem[rd_ptr];

  // Gate the head so idle outputs read as zero.
  assign OUT_TDATA = OUT_TVALID ? head[OUTW-1:0] : '0;
  assign OUT_TLAST = OUT_TVALID && head[OUTW];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {last_in, y_sat};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      word_idx    <= '0;
      frame_count <= '0;
      sat_flag    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        word_idx <= last_in ? '0 : word_idx + 1'b1;
        if (sat_hit) begin
          sat_flag <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (head[OUTW]) begin
          frame_count <= frame_count + 16'd1;
        end
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
